// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared widths, saturation limits and FSM states for the neuron accumulator
package neuron_pkg;

  localparam int ACC_W  = 16;
  localparam int TERM_W = 8;

  localparam logic signed [ACC_W-1:0] ACC_MAX = 16'sh7FFF;
  localparam logic signed [ACC_W-1:0] ACC_MIN = 16'sh8000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

endpackage

// File: rtl/neuron_adder.sv
// rtl/neuron_adder.sv - registered signed adder: in1 + sign-extended in2 -> sum with carry (bit 16)
module neuron_adder
  import neuron_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [ACC_W-1:0]  in1,
  input  logic signed [TERM_W-1:0] in2,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     carry
);

  logic [ACC_W:0] full;

  assign full = {in1[ACC_W-1], in1} + {{(ACC_W+1-TERM_W){in2[TERM_W-1]}}, in2};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      sum   <= full[ACC_W-1:0];
      carry <= full[ACC_W];
    end
  end

endmodule

// File: rtl/neuron_accum_ctrl.sv
// rtl/neuron_accum_ctrl.sv - burst accumulator controller driving an external registered adder
module neuron_accum_ctrl
  import neuron_pkg::*;
#(
  parameter int N_MAX   = 16,
  parameter int ADD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [ACC_W-1:0]      init_val,
  input  logic                         term_valid,
  input  logic signed [TERM_W-1:0]     term_data,
  input  logic                         term_last,
  output logic                         term_ready,
  output logic signed [ACC_W-1:0]      add_in1,
  output logic signed [TERM_W-1:0]     add_in2,
  input  logic signed [ACC_W-1:0]      add_sum,
  input  logic                         add_carry,
  output logic                         res_valid,
  output logic signed [ACC_W-1:0]      res_data,
  output logic                         res_sat,
  output logic [$clog2(N_MAX+1)-1:0]   res_count,
  input  logic                         res_ready,
  output logic                         busy
);

  localparam int CNT_W  = $clog2(N_MAX + 1);
  localparam int WAIT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(N_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ADD_LAT);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        count, count_inc;
  logic                    sat, last_q;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    accept, capture, ovf;

  assign count_inc = count + CNT_W'(1);
  // Signed overflow: the 17-bit result's sign disagrees with the truncated sum's sign.
  assign ovf       = add_carry ^ add_sum[ACC_W-1];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    term_ready = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = ISSUE;
      end
      ISSUE: begin
        term_ready = 1'b1;
        if (term_valid) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          capture = 1'b1;
          state_d = last_q ? DONE : ISSUE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      sat      <= 1'b0;
      last_q   <= 1'b0;
      wait_cnt <= '0;
      add_in1  <= '0;
      add_in2  <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        acc   <= init_val;
        count <= '0;
        sat   <= 1'b0;
      end
      if (accept) begin
        add_in1  <= acc;
        add_in2  <= term_data;
        count    <= count_inc;
        last_q   <= term_last | (count_inc == CNT_LIMIT);
        wait_cnt <= '0;
      end
      if (capture) begin
        if (ovf) begin
          acc <= add_carry ? ACC_MIN : ACC_MAX;
          sat <= 1'b1;
        end else begin
          acc <= add_sum;
        end
      end else if (state_q == WAIT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  assign res_data  = acc;
  assign res_sat   = sat;
  assign res_count = count;

endmodule

// File: tb/tb_neuron_accum_ctrl.sv
// tb/tb_neuron_accum_ctrl.sv - scoreboard bench for neuron_accum_ctrl with the real registered adder
module tb_neuron_accum_ctrl;
  import neuron_pkg::*;

  localparam int N_MAX = 16;
  localparam int CW    = $clog2(N_MAX + 1);

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic signed [ACC_W-1:0]  init_val = '0;
  logic                     term_valid = 1'b0;
  logic signed [TERM_W-1:0] term_data = '0;
  logic                     term_last = 1'b0;
  logic                     res_ready = 1'b0;
  logic                     term_ready, res_valid, res_sat, busy, add_carry;
  logic signed [ACC_W-1:0]  add_in1, add_sum, res_data;
  logic signed [TERM_W-1:0] add_in2;
  logic [CW-1:0]            res_count;

  always #5 clk = ~clk;

  neuron_accum_ctrl #(.N_MAX(N_MAX), .ADD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .init_val(init_val),
    .term_valid(term_valid), .term_data(term_data), .term_last(term_last),
    .term_ready(term_ready), .add_in1(add_in1), .add_in2(add_in2),
    .add_sum(add_sum), .add_carry(add_carry), .res_valid(res_valid),
    .res_data(res_data), .res_sat(res_sat), .res_count(res_count),
    .res_ready(res_ready), .busy(busy)
  );

  neuron_adder u_add (
    .clk(clk), .rst_n(~rst), .in1(add_in1), .in2(add_in2),
    .sum(add_sum), .carry(add_carry)
  );

  typedef struct {
    int data;
    int sat;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference: plain integer accumulation with clamping to the 16-bit signed range.
  function automatic exp_t model(input int init, input int terms[$]);
    exp_t e;
    int   a;
    a     = init;
    e.sat = 0;
    e.cnt = 0;
    foreach (terms[i]) begin
      a = a + terms[i];
      if (a > 32767) begin
        a = 32767;
        e.sat = 1;
      end else if (a < -32768) begin
        a = -32768;
        e.sat = 1;
      end
      e.cnt++;
    end
    e.data = a;
    return e;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", int'(res_valid), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_data", int'(res_data), e.data);
          check("res_sat", int'(res_sat), e.sat);
          check("res_count", int'(res_count), e.cnt);
        end
      end
    end
  end

  task automatic do_start(input int init);
    @(negedge clk);
    init_val = ACC_W'(init);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Returns on the negedge after the edge following the handshake (adder still in flight).
  task automatic send_term(input int d, input bit l);
    int t;
    t          = 0;
    term_valid = 1'b1;
    term_data  = TERM_W'(d);
    term_last  = l;
    while (!term_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!term_ready) begin
      check("term_handshake", int'(term_ready), 1);
      term_valid = 1'b0;
      return;
    end
    @(negedge clk);
    term_valid = 1'b0;
    term_last  = 1'b0;
    check("term_ready_wait1", int'(term_ready), 0);
    check("res_valid_wait1", int'(res_valid), 0);
    @(negedge clk);
    check("term_ready_wait2", int'(term_ready), 0);
    check("res_valid_wait2", int'(res_valid), 0);
  endtask

  task automatic wait_result();
    int t;
    t = 0;
    while (!res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("res_valid_seen", int'(res_valid), 1);
  endtask

  task automatic accept_result(input int hold);
    repeat (hold) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic run_burst(input int init, input int terms[$], input bit use_last, input int hold);
    sb.push_back(model(init, terms));
    do_start(init);
    foreach (terms[i]) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_term(terms[i], use_last && (i == terms.size() - 1));
    end
    wait_result();
    accept_result(hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   q[$];
    exp_t e;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_term_ready", int'(term_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_add_in1", int'(add_in1), 0);
    check("rst_add_in2", int'(add_in2), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_res_count", int'(res_count), 0);
    check("rst_res_sat", int'(res_sat), 0);

    // Single term: result must appear exactly on the third edge after the handshake.
    q = {27};
    sb.push_back(model(100, q));
    do_start(100);
    send_term(27, 1'b1);
    @(negedge clk);
    check("res_valid_k3", int'(res_valid), 1);
    accept_result(0);

    q = {-20, 10, -5};
    run_burst(50, q, 1'b1, 2);
    q = {1};
    run_burst(32767, q, 1'b1, 0);
    q = {-1, 5};
    run_burst(-32768, q, 1'b1, 1);

    // 17 terms with no last flag: the 16th closes the burst, the 17th waits upstream.
    q = {};
    for (int i = 0; i < N_MAX; i++) q.push_back(1);
    e = model(0, q);
    sb.push_back(e);
    do_start(0);
    foreach (q[i]) send_term(1, 1'b0);
    wait_result();
    term_valid = 1'b1;
    term_data  = TERM_W'(1);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      @(negedge clk);
      check("stall_term_ready", int'(term_ready), 0);
      check("stall_res_valid", int'(res_valid), 1);
      check("stall_res_data", int'(res_data), e.data);
      check("stall_res_count", int'(res_count), e.cnt);
    end
    start = 1'b0;
    accept_result(0);
    check("after_done_busy", int'(busy), 0);
    check("after_done_res_valid", int'(res_valid), 0);
    term_valid = 1'b0;

    // Reset while the adder result is in flight.
    do_start(1234);
    term_valid = 1'b1;
    term_data  = TERM_W'(5);
    term_last  = 1'b1;
    @(negedge clk);
    term_valid = 1'b0;
    term_last  = 1'b0;
    check("midburst_add_in1", int'(add_in1), 1234);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_term_ready", int'(term_ready), 0);
    check("midrst_res_valid", int'(res_valid), 0);
    check("midrst_add_in1", int'(add_in1), 0);
    check("midrst_add_in2", int'(add_in2), 0);
    check("midrst_res_count", int'(res_count), 0);

    for (int b = 0; b < 30; b++) begin
      int  n;
      int  init;
      bit  use_last;
      n        = $urandom_range(1, N_MAX);
      init     = int'($urandom_range(0, 65535)) - 32768;
      use_last = (n == N_MAX) ? bit'($urandom_range(0, 1)) : 1'b1;
      q = {};
      for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(0, 255)) - 128);
      run_burst(init, q, use_last, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
